// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole round scheduler: state encoding,
// light count, LFSR constants and a saturating counter helper.
package wam_pkg;

  localparam int NUM_LIGHTS = 9;
  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'h0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PICK  = 3'd2,
    ST_ON    = 3'd3,
    ST_SCORE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Score counters stick at their maximum instead of wrapping.
  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c == 6'h3F) ? c : c + 6'd1;
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running Galois LFSR; a zero seed is replaced so the register never locks up.
module wam_lfsr
  import wam_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [LFSR_WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= LFSR_SEED;
    end else if (load) begin
      value <= (seed == '0) ? LFSR_SEED : seed;
    end else begin
      value <= (value >> 1) ^ (value[0] ? LFSR_MASK : '0);
    end
  end

endmodule

// File: rtl/wam_round_scheduler.sv
// Game sequencer: waits, lights a pseudo-random mole, scores hit or miss,
// and ends the game after the configured rounds or a deathmatch miss.
module wam_round_scheduler
  import wam_pkg::*;
#(
  parameter int N_LIGHTS = NUM_LIGHTS,
  parameter int TW       = 28,
  parameter int LFSR_W   = LFSR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                load_seed,
  input  logic [LFSR_W-1:0]   seed,
  input  logic [TW-1:0]       time_between,
  input  logic [TW-1:0]       time_on,
  input  logic [5:0]          total_rounds,
  input  logic                deathmatch,
  input  logic                key_valid,
  input  logic [3:0]          key_idx,
  output logic [N_LIGHTS-1:0] lights,
  output logic [5:0]          hits,
  output logic [5:0]          misses,
  output logic [5:0]          round_cnt,
  output logic                busy,
  output logic                game_over,
  output state_t              fsm_state
);

  localparam logic [3:0] IDX_NONE = 4'(N_LIGHTS);

  state_t            state, state_nx;
  logic [TW-1:0]     timer;
  logic [3:0]        cur_idx, prev_idx, pick_idx, raw_idx;
  logic              hit_flag;
  logic [LFSR_W-1:0] lfsr_val;
  logic              wait_done, key_hit, on_timeout, last_round;
  logic              unused_lfsr;

  wam_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (load_seed),
    .seed  (seed),
    .value (lfsr_val)
  );

  assign unused_lfsr = ^lfsr_val[LFSR_W-1:4];

  // Only the low nibble is used: one conditional subtract, then bump on repeat.
  always_comb begin
    raw_idx  = (lfsr_val[3:0] >= 4'(N_LIGHTS)) ? lfsr_val[3:0] - 4'(N_LIGHTS) : lfsr_val[3:0];
    pick_idx = raw_idx;
    if (raw_idx == prev_idx) begin
      pick_idx = (raw_idx == 4'(N_LIGHTS - 1)) ? 4'd0 : raw_idx + 4'd1;
    end
  end

  assign wait_done  = (state == ST_WAIT) && (timer == time_between);
  assign key_hit    = (state == ST_ON) && key_valid && (key_idx == cur_idx);
  assign on_timeout = (state == ST_ON) && (timer == time_on);
  assign last_round = ({1'b0, round_cnt} + 7'd1) == {1'b0, total_rounds};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = (total_rounds == 6'd0) ? ST_DONE : ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:  if (wait_done) state_nx = ST_PICK;
        ST_PICK:  state_nx = ST_ON;
        ST_ON:    if (key_hit || on_timeout) state_nx = ST_SCORE;
        ST_SCORE: state_nx = (last_round || (deathmatch && !hit_flag)) ? ST_DONE : ST_WAIT;
        default:  state_nx = state;
      endcase
    end
  end

  always_comb begin
    busy      = (state == ST_WAIT) || (state == ST_PICK) || (state == ST_ON) || (state == ST_SCORE);
    game_over = (state == ST_DONE);
    fsm_state = state;
  end

  // A hit wins over a same-cycle timeout because it is tested first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer     <= '0;
      lights    <= '0;
      hits      <= '0;
      misses    <= '0;
      round_cnt <= '0;
      cur_idx   <= '0;
      prev_idx  <= IDX_NONE;
      hit_flag  <= 1'b0;
    end else if (start) begin
      timer     <= '0;
      lights    <= '0;
      hits      <= '0;
      misses    <= '0;
      round_cnt <= '0;
      prev_idx  <= IDX_NONE;
      hit_flag  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: timer <= wait_done ? '0 : timer + 1'b1;
        ST_PICK: begin
          cur_idx  <= pick_idx;
          prev_idx <= pick_idx;
          lights   <= N_LIGHTS'(1) << pick_idx;
        end
        ST_ON: begin
          if (key_hit) begin
            hits     <= sat_inc(hits);
            hit_flag <= 1'b1;
          end else if (on_timeout) begin
            misses   <= sat_inc(misses);
            hit_flag <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_SCORE: begin
          lights    <= '0;
          round_cnt <= sat_inc(round_cnt);
          timer     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wam_round_scheduler.sv
// Randomized self-checking bench for wam_round_scheduler against a
// round-level reference model of the game rules.
module tb_wam_round_scheduler;
  import wam_pkg::*;

  localparam int TW = 28;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          load_seed = 1'b0;
  logic [15:0]   seed = '0;
  logic [TW-1:0] time_between = '0;
  logic [TW-1:0] time_on = '0;
  logic [5:0]    total_rounds = '0;
  logic          deathmatch = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_idx = '0;
  logic [8:0]    lights;
  logic [5:0]    hits, misses, round_cnt;
  logic          busy, game_over;
  state_t        fsm_state;

  wam_round_scheduler #(.N_LIGHTS(9), .TW(TW), .LFSR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_seed    (load_seed),
    .seed         (seed),
    .time_between (time_between),
    .time_on      (time_on),
    .total_rounds (total_rounds),
    .deathmatch   (deathmatch),
    .key_valid    (key_valid),
    .key_idx      (key_idx),
    .lights       (lights),
    .hits         (hits),
    .misses       (misses),
    .round_cnt    (round_cnt),
    .busy         (busy),
    .game_over    (game_over),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int         n_tests = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference random source: x^16+x^14+x^13+x^11+1 in Galois (right-shift) form.
  logic [15:0] m_lfsr, m_last;

  function automatic logic [15:0] galois_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 16'h0001;
      m_last <= 16'h0001;
    end else begin
      m_last <= m_lfsr;
      m_lfsr <= load_seed ? ((seed == 16'h0) ? 16'h0001 : seed) : galois_step(m_lfsr);
    end
  end

  function automatic int pick_model(input logic [15:0] l, input int prev);
    int i;
    i = int'(l[3:0]) % 9;
    if (i == prev) i = (i + 1) % 9;
    return i;
  endfunction

  int prev_m, e_hits, e_misses, e_rounds;

  // driver tasks
  task automatic start_game(input int tb, input int to, input int rounds, input bit dm);
    time_between = TW'(tb);
    time_on      = TW'(to);
    total_rounds = 6'(rounds);
    deathmatch   = dm;
    start        = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    e_hits   = 0;
    e_misses = 0;
    e_rounds = 0;
    prev_m   = 9;
    check("start_busy", busy, rounds != 0);
    check("start_over", game_over, rounds == 0);
    check("start_clear", {lights, hits, misses, round_cnt}, 0);
  endtask

  // Entered on the first WAIT cycle; returns on the cycle after SCORE.
  task automatic play_round(input int pol_in, input int k_in, output bit finished);
    int tb, to, pol, k, idx;
    bit hit;
    tb  = int'(time_between);
    to  = int'(time_on);
    pol = (pol_in < 0) ? int'($urandom_range(0, 3)) : pol_in;
    for (int c = 0; c <= tb; c++) begin
      if (c == 0 && $urandom_range(0, 1) == 1) begin
        key_valid = 1'b1;
        key_idx   = (prev_m == 9) ? 4'($urandom_range(0, 8)) : 4'(prev_m);
      end
      @(negedge clk);
      key_valid = 1'b0;
    end
    check("pick_dark", lights, 0);
    @(negedge clk);
    idx    = pick_model(m_last, prev_m);
    prev_m = idx;
    exp_q.push_back(9'(1) << idx);
    check("light_onset", lights, exp_q.pop_front());
    hit = (pol == 0) || (pol == 3);
    if (hit) begin
      k = (pol == 3) ? to : ((k_in >= 0) ? k_in : int'($urandom_range(0, to)));
      repeat (k) @(negedge clk);
      key_valid = 1'b1;
      key_idx   = 4'(idx);
      @(negedge clk);
      key_valid = 1'b0;
      e_hits++;
    end else begin
      if (pol == 2) begin
        key_valid = 1'b1;
        key_idx   = ($urandom_range(0, 1) == 1) ? 4'((idx + 1 + int'($urandom_range(0, 7))) % 9)
                                                : 4'($urandom_range(9, 15));
        @(negedge clk);
        key_valid = 1'b0;
        repeat (to) @(negedge clk);
      end else begin
        repeat (to + 1) @(negedge clk);
      end
      e_misses++;
    end
    check("score_hits", hits, e_hits);
    check("score_misses", misses, e_misses);
    check("score_lit", lights, 9'(1) << idx);
    @(negedge clk);
    e_rounds++;
    finished = (e_rounds == int'(total_rounds)) || (deathmatch && !hit);
    check("round_cnt", round_cnt, e_rounds);
    check("round_dark", lights, 0);
    check("round_over", game_over, finished);
    check("round_busy", busy, !finished);
  endtask

  task automatic run_game(input int tb, input int to, input int rounds, input bit dm,
                          input int pol, input int k);
    bit fin;
    fin = 1'b0;
    start_game(tb, to, rounds, dm);
    for (int r = 0; r < rounds && !fin; r++) play_round(pol, k, fin);
    key_valid = 1'b1;
    key_idx   = 4'(prev_m);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("done_frozen", {hits, misses, round_cnt}, {6'(e_hits), 6'(e_misses), 6'(e_rounds)});
    check("done_state", fsm_state, ST_DONE);
    check("done_over", game_over, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {lights, hits, misses, round_cnt, busy, game_over}, 0);
    check("reset_state", fsm_state, ST_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {lights, hits, misses, round_cnt, busy, game_over}, 0);

    run_game(3, 5, 2, 1'b0, 0, 2);
    run_game(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 3, 1'b0, 1, -1);
    run_game(2, 3, 25, 1'b1, 2, -1);
    run_game(1, 4, 3, 1'b0, 3, -1);

    start_game(2, 2, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("zero_rounds_over", game_over, 1);
    check("zero_rounds_cnt", round_cnt, 0);

    seed      = 16'h0000;
    load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    run_game(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 4, 1'b0, -1, -1);

    seed      = 16'hACE1;
    load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    run_game(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 50, 1'b0, -1, -1);

    repeat (4) run_game(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                        int'($urandom_range(3, 10)), 1'b1, -1, -1);

    start_game(2, 10, 5, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_lit", lights != 0, 1);
    reset = 1'b0;
    #1;
    check("async_reset", {lights, hits, misses, round_cnt, busy, game_over}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_reset_idle", {lights, hits, misses, round_cnt, busy, game_over}, 0);
    end
    run_game(1, 2, 3, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
